// File: rtl/multi_flasher.sv
// Multi-channel flasher: channels share one half-period timebase and phase,
// with optional antiphase on odd channels and a per-channel level while disabled.
module multi_flasher #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int HALF_PERIOD = 5000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] off_state,
  input  logic [CNT_W-1:0]  half_period,
  input  logic              alt_phase,
  output logic [NUM_CH-1:0] out,
  output logic              phase_tick,
  output logic              busy
);

  logic             active;
  logic [CNT_W-1:0] cnt_reg;
  logic             phase_reg;
  logic [CNT_W-1:0] hp_reg;
  logic             alt_reg;
  logic [CNT_W-1:0] hp_load;
  logic             wrap;

  assign active  = |enable;
  // A requested half-period of zero would never wrap, so it is clamped to one.
  assign hp_load = (half_period == '0) ? CNT_W'(1) : half_period;
  // hp_reg only changes while idle (cnt cleared), so >= is a safe guard.
  assign wrap    = (cnt_reg >= hp_reg - CNT_W'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg    <= '0;
      phase_reg  <= 1'b1;
      hp_reg     <= CNT_W'(HALF_PERIOD);
      alt_reg    <= 1'b0;
      phase_tick <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= active;
      if (!active) begin
        cnt_reg    <= '0;
        phase_reg  <= 1'b1;
        hp_reg     <= hp_load;
        alt_reg    <= alt_phase;
        phase_tick <= 1'b0;
      end else if (wrap) begin
        cnt_reg    <= '0;
        phase_reg  <= ~phase_reg;
        phase_tick <= 1'b1;
      end else begin
        cnt_reg    <= cnt_reg + CNT_W'(1);
        phase_tick <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam bit ODD = ((gi % 2) == 1);
      always_ff @(posedge clock) begin
        if (reset) begin
          out[gi] <= 1'b0;
        end else if (enable[gi]) begin
          out[gi] <= phase_reg ^ (alt_reg & ODD);
        end else begin
          out[gi] <= off_state[gi];
        end
      end
    end
  endgenerate

endmodule
